// File: rtl/mmio_initiator_pkg.sv
// Shared types for the MMIO initiator: access sizes, FSM states and the default address width.
// Used by mmio_initiator.sv (optional feature macro MMIO_INIT_RMW_EN).
package mmio_pkg;

  localparam int PER_ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Size/alignment legality only; the store-without-RMW rule lives in the top.
  function automatic logic access_illegal(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: access_illegal = 1'b0;
      SZ_HALF: access_illegal = lo[0];
      SZ_WORD: access_illegal = (lo != 2'b00);
      default: access_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mmio_initiator_if.sv
// CPU request/response and peripheral bus bundle for the MMIO initiator.
// The initiator uses the slave modport; the CPU/peripheral side uses master.
interface mmio_initiator_if #(parameter int PER_ADDR_W = mmio_pkg::PER_ADDR_W_DEF);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [31:0]           req_addr_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic [PER_ADDR_W-1:0] per_addr_o;
  logic                  per_write_en_o;
  logic [31:0]           per_data_o;
  logic [31:0]           per_data_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  per_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output per_addr_o, per_write_en_o, per_data_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output per_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  per_addr_o, per_write_en_o, per_data_o
  );

endinterface

// File: rtl/mmio_initiator_lane_align.sv
// Combinational byte-lane logic: extracts/extends a load from a peripheral word and
// merges right-aligned store data into a peripheral word for read-modify-write.
module mmio_lane_align
  import mmio_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    half_sel = rword_i[{lane_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_o = rword_i;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       sel;
      logic [7:0] src;

      // Store data is right-aligned, so a half's upper byte comes from wdata[15:8].
      always_comb begin
        case (size_i)
          SZ_BYTE: begin
            sel = (lane_i == LANE);
            src = wdata_i[7:0];
          end
          SZ_HALF: begin
            sel = (lane_i[1] == LANE[1]);
            src = wdata_i[8*(gi%2) +: 8];
          end
          default: begin
            sel = 1'b1;
            src = wdata_i[8*gi +: 8];
          end
        endcase
      end

      assign merge_o[8*gi +: 8] = sel ? src : rword_i[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mmio_initiator.sv
// MMIO initiator: turns CPU byte/half/word loads and stores into word-wide peripheral accesses.
// Define MMIO_INIT_RMW_EN to implement sub-word stores as read-modify-write; otherwise they error.
module mmio_initiator
  import mmio_pkg::*;
#(
  parameter int PER_ADDR_W = PER_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mmio_initiator_if.slave   bus
);

`ifdef MMIO_INIT_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  state_e                state_q;
  logic [1:0]            addr_lo_q;
  size_e                 size_q;
  logic                  we_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [31:0]           rsp_rdata_q;
  logic                  per_we_q;
  logic [PER_ADDR_W-1:0] per_addr_q;
  logic [31:0]           per_data_q;

  size_e       req_size_d;
  logic        req_err_d;
  logic [31:0] load_word_d;
  logic [31:0] merge_word_d;
  logic        unused_addr_bits;

  assign req_size_d       = size_e'(bus.req_size_i);
  assign req_err_d        = access_illegal(req_size_d, bus.req_addr_i[1:0]) ||
                            (!RMW_EN && bus.req_we_i && (req_size_d != SZ_WORD));
  assign unused_addr_bits = ^bus.req_addr_i[31:PER_ADDR_W];

  mmio_lane_align u_lane_align (
    .size_i     (size_q),
    .lane_i     (addr_lo_q),
    .unsigned_i (uns_q),
    .rword_i    (bus.per_data_i),
    .wdata_i    (wdata_q),
    .load_o     (load_word_d),
    .merge_o    (merge_word_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_lo_q   <= 2'b00;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      per_we_q    <= 1'b0;
      per_addr_q  <= '0;
      per_data_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            addr_lo_q <= bus.req_addr_i[1:0];
            size_q    <= req_size_d;
            we_q      <= bus.req_we_i;
            uns_q     <= bus.req_unsigned_i;
            wdata_q   <= bus.req_wdata_i;
            // Rejected requests leave the peripheral address untouched.
            if (req_err_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else if (!bus.req_we_i || (req_size_d != SZ_WORD)) begin
              state_q    <= READ;
              per_addr_q <= {bus.req_addr_i[PER_ADDR_W-1:2], 2'b00};
            end else begin
              state_q    <= WRITE;
              per_addr_q <= {bus.req_addr_i[PER_ADDR_W-1:2], 2'b00};
              per_data_q <= bus.req_wdata_i;
              per_we_q   <= 1'b1;
            end
          end
        end
        READ: begin
          if (we_q) begin
            state_q    <= WRITE;
            per_data_q <= merge_word_d;
            per_we_q   <= 1'b1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_word_d;
          end
        end
        WRITE: begin
          state_q     <= RESP;
          per_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= 32'h0;
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o    = (state_q == IDLE);
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_err_o      = rsp_err_q;
  assign bus.rsp_rdata_o    = rsp_rdata_q;
  assign bus.per_write_en_o = per_we_q;
  assign bus.per_addr_o     = per_addr_q;
  assign bus.per_data_o     = per_data_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Randomized bench for mmio_initiator against a word-array peripheral and an arithmetic model.
// Honors MMIO_INIT_RMW_EN the same way the design does.
module tb_mmio_initiator;
  import mmio_pkg::*;

  localparam int AW = 8;

`ifdef MMIO_INIT_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmio_initiator_if #(.PER_ADDR_W(AW)) bus ();

  mmio_initiator #(.PER_ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Peripheral: 64-word register file, combinational read, strobed write.
  logic [31:0] tb_mem [64];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;

  always @(posedge clk) begin
    if (poke_en) tb_mem[poke_idx] <= poke_val;
    else if (bus.per_write_en_o) tb_mem[bus.per_addr_o[7:2]] <= bus.per_data_o;
  end
  assign bus.per_data_i = tb_mem[bus.per_addr_o[7:2]];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [64];
  logic [7:0]  model_paddr;

  // observed
  int          g_lat, g_nstb;
  logic        g_err, g_tail;
  logic [31:0] g_rd, g_wv;
  logic [7:0]  g_wa, g_pa1;
  // expected
  int          x_lat, x_nstb;
  logic        x_err;
  logic [31:0] x_rd, x_wv;
  logic [7:0]  x_pa;

  task automatic poke(input int i, input logic [31:0] v);
    poke_en  = 1'b1;
    poke_idx = 6'(i);
    poke_val = v;
    @(posedge clk);
    #1;
    poke_en    = 1'b0;
    ref_mem[i] = v;
  endtask

  task automatic model_access(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic uns, input logic [31:0] wd,
                              output logic e, output logic [31:0] rd, output int lat,
                              output int nstb, output logic [7:0] pa, output logic [31:0] wv);
    int          idx, sh;
    logic [31:0] old, mask, val;
    idx  = int'(a[7:2]);
    sh   = 8 * int'(a[1:0]);
    old  = ref_mem[idx];
    e    = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           (we && sz != 2'd2 && !RMW);
    rd   = 32'h0;
    nstb = 0;
    wv   = 32'h0;
    if (e) begin
      lat = 1;
      pa  = model_paddr;
    end else begin
      model_paddr = {a[7:2], 2'b00};
      pa   = model_paddr;
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (!we) begin
        val = (old >> sh) & mask;
        if (!uns && sz == 2'd0 && val[7])  val = val | 32'hFFFF_FF00;
        if (!uns && sz == 2'd1 && val[15]) val = val | 32'hFFFF_0000;
        rd  = val;
        lat = 2;
      end else begin
        wv           = (old & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[idx] = wv;
        nstb         = 1;
        lat          = (sz == 2'd2) ? 2 : 3;
      end
    end
  endtask

  // Issues one request and observes it; must be called while the DUT is idle.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output int lat, output logic e, output logic [31:0] rd,
                         output int nstb, output logic [7:0] wa, output logic [31:0] wv,
                         output logic [7:0] pa1, output logic tail_ok);
    logic done;
    tail_ok            = bus.req_ready_o;
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_addr_i     = a;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_wdata_i    = wd;
    @(posedge clk);
    #1;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'($urandom);
    bus.req_addr_i     = $urandom;
    bus.req_size_i     = 2'($urandom);
    bus.req_wdata_i    = $urandom;
    lat = 0; e = 1'b0; rd = 32'h0; nstb = 0; wa = 8'h0; wv = 32'h0; pa1 = 8'h0;
    done = 1'b0;
    for (int k = 1; k <= 6 && !done; k++) begin
      @(negedge clk);
      if (k == 1) pa1 = bus.per_addr_o;
      if (bus.per_write_en_o) begin
        nstb++;
        wa = bus.per_addr_o;
        wv = bus.per_data_o;
      end
      if (bus.rsp_valid_o) begin
        lat  = k;
        e    = bus.rsp_err_o;
        rd   = bus.rsp_rdata_o;
        done = 1'b1;
      end
    end
    @(negedge clk);
    tail_ok = tail_ok && !bus.rsp_valid_o && !bus.per_write_en_o && bus.req_ready_o;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.req_ready_o !== 1'b1)       begin bad++; $display("FAIL rst_ready got=%b want=1", bus.req_ready_o); end
    total++; if (bus.rsp_valid_o !== 1'b0)       begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid_o); end
    total++; if (bus.rsp_err_o !== 1'b0)         begin bad++; $display("FAIL rst_err got=%b want=0", bus.rsp_err_o); end
    total++; if (bus.rsp_rdata_o !== 32'h0)      begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.rsp_rdata_o); end
    total++; if (bus.per_write_en_o !== 1'b0)    begin bad++; $display("FAIL rst_wen got=%b want=0", bus.per_write_en_o); end
    total++; if (bus.per_addr_o !== 8'h0)        begin bad++; $display("FAIL rst_paddr got=%h want=0", bus.per_addr_o); end
    total++; if (bus.per_data_o !== 32'h0)       begin bad++; $display("FAIL rst_pdata got=%h want=0", bus.per_data_o); end
    reset       = 1'b0;
    model_paddr = 8'h0;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    $display("txn reset: checks done");
  endtask

  task automatic test_word_store;
    model_access(1'b1, 32'h10, 2'd2, 1'b0, 32'h1234_5678, x_err, x_rd, x_lat, x_nstb, x_pa, x_wv);
    run_txn(1'b1, 32'h10, 2'd2, 1'b0, 32'h1234_5678, g_lat, g_err, g_rd, g_nstb, g_wa, g_wv, g_pa1, g_tail);
    total++; if (g_lat !== 2)            begin bad++; $display("FAIL wst_lat got=%0d want=2", g_lat); end
    total++; if (g_err !== 1'b0)         begin bad++; $display("FAIL wst_err got=%b want=0", g_err); end
    total++; if (g_nstb !== 1)           begin bad++; $display("FAIL wst_strobes got=%0d want=1", g_nstb); end
    total++; if (g_wa !== 8'h10)         begin bad++; $display("FAIL wst_paddr got=%h want=10", g_wa); end
    total++; if (g_wv !== 32'h1234_5678) begin bad++; $display("FAIL wst_pdata got=%h want=12345678", g_wv); end
    total++; if (g_tail !== 1'b1)        begin bad++; $display("FAIL wst_tail got=%b want=1", g_tail); end
    $display("txn word store @10 lat=%0d err=%b data=%h", g_lat, g_err, g_wv);
  endtask

  task automatic test_byte_load;
    poke(1, 32'h0000_80FF);
    for (int u = 0; u < 2; u++) begin
      model_access(1'b0, 32'h05, 2'd0, 1'(u), 32'h0, x_err, x_rd, x_lat, x_nstb, x_pa, x_wv);
      run_txn(1'b0, 32'h05, 2'd0, 1'(u), 32'h0, g_lat, g_err, g_rd, g_nstb, g_wa, g_wv, g_pa1, g_tail);
      total++; if (g_lat !== 2)     begin bad++; $display("FAIL bld_lat got=%0d want=2", g_lat); end
      total++; if (g_pa1 !== 8'h04) begin bad++; $display("FAIL bld_paddr got=%h want=04", g_pa1); end
      total++; if (g_rd !== ((u == 1) ? 32'h0000_0080 : 32'hFFFF_FF80))
        begin bad++; $display("FAIL bld_rdata uns=%0d got=%h want=%h", u, g_rd, (u == 1) ? 32'h80 : 32'hFFFF_FF80); end
      total++; if (g_nstb !== 0)    begin bad++; $display("FAIL bld_strobes got=%0d want=0", g_nstb); end
      $display("txn byte load @05 uns=%0d rdata=%h lat=%0d", u, g_rd, g_lat);
    end
  endtask

  task automatic test_misaligned;
    model_access(1'b0, 32'h03, 2'd1, 1'b0, 32'h0, x_err, x_rd, x_lat, x_nstb, x_pa, x_wv);
    run_txn(1'b0, 32'h03, 2'd1, 1'b0, 32'h0, g_lat, g_err, g_rd, g_nstb, g_wa, g_wv, g_pa1, g_tail);
    total++; if (g_lat !== 1)     begin bad++; $display("FAIL mis_lat got=%0d want=1", g_lat); end
    total++; if (g_err !== 1'b1)  begin bad++; $display("FAIL mis_err got=%b want=1", g_err); end
    total++; if (g_rd !== 32'h0)  begin bad++; $display("FAIL mis_rdata got=%h want=0", g_rd); end
    total++; if (g_nstb !== 0)    begin bad++; $display("FAIL mis_strobes got=%0d want=0", g_nstb); end
    total++; if (g_pa1 !== 8'h04) begin bad++; $display("FAIL mis_paddr got=%h want=04", g_pa1); end
    $display("txn half load @03 err=%b lat=%0d", g_err, g_lat);
    model_access(1'b1, 32'h06, 2'd2, 1'b0, 32'hDEAD_BEEF, x_err, x_rd, x_lat, x_nstb, x_pa, x_wv);
    run_txn(1'b1, 32'h06, 2'd2, 1'b0, 32'hDEAD_BEEF, g_lat, g_err, g_rd, g_nstb, g_wa, g_wv, g_pa1, g_tail);
    total++; if (g_err !== 1'b1 || g_nstb !== 0 || g_lat !== 1)
      begin bad++; $display("FAIL mis_word err=%b strobes=%0d lat=%0d want 1/0/1", g_err, g_nstb, g_lat); end
    $display("txn word store @06 err=%b lat=%0d", g_err, g_lat);
    model_access(1'b0, 32'h08, 2'd3, 1'b0, 32'h0, x_err, x_rd, x_lat, x_nstb, x_pa, x_wv);
    run_txn(1'b0, 32'h08, 2'd3, 1'b0, 32'h0, g_lat, g_err, g_rd, g_nstb, g_wa, g_wv, g_pa1, g_tail);
    total++; if (g_err !== 1'b1 || g_lat !== 1)
      begin bad++; $display("FAIL mis_size3 err=%b lat=%0d want 1/1", g_err, g_lat); end
    $display("txn size3 load @08 err=%b lat=%0d", g_err, g_lat);
  endtask

  task automatic test_subword_store;
`ifdef MMIO_INIT_RMW_EN
    poke(0, 32'h1122_3344);
    model_access(1'b1, 32'h02, 2'd0, 1'b0, 32'h0000_00AB, x_err, x_rd, x_lat, x_nstb, x_pa, x_wv);
    run_txn(1'b1, 32'h02, 2'd0, 1'b0, 32'h0000_00AB, g_lat, g_err, g_rd, g_nstb, g_wa, g_wv, g_pa1, g_tail);
    total++; if (g_lat !== 3)            begin bad++; $display("FAIL rmw_lat got=%0d want=3", g_lat); end
    total++; if (g_err !== 1'b0)         begin bad++; $display("FAIL rmw_err got=%b want=0", g_err); end
    total++; if (g_nstb !== 1)           begin bad++; $display("FAIL rmw_strobes got=%0d want=1", g_nstb); end
    total++; if (g_wv !== 32'h11AB_3344) begin bad++; $display("FAIL rmw_pdata got=%h want=11ab3344", g_wv); end
    total++; if (g_wa !== 8'h00)         begin bad++; $display("FAIL rmw_paddr got=%h want=00", g_wa); end
    $display("txn rmw byte store @02 data=%h lat=%0d", g_wv, g_lat);
`else
    model_access(1'b1, 32'h00, 2'd1, 1'b0, 32'h0000_BEEF, x_err, x_rd, x_lat, x_nstb, x_pa, x_wv);
    run_txn(1'b1, 32'h00, 2'd1, 1'b0, 32'h0000_BEEF, g_lat, g_err, g_rd, g_nstb, g_wa, g_wv, g_pa1, g_tail);
    total++; if (g_lat !== 1)    begin bad++; $display("FAIL sws_lat got=%0d want=1", g_lat); end
    total++; if (g_err !== 1'b1) begin bad++; $display("FAIL sws_err got=%b want=1", g_err); end
    total++; if (g_nstb !== 0)   begin bad++; $display("FAIL sws_strobes got=%0d want=0", g_nstb); end
    $display("txn half store @00 err=%b lat=%0d", g_err, g_lat);
`endif
  endtask

  task automatic test_reset_abort;
    int n_stb, n_rsp;
    poke(2, 32'hCAFE_F00D);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = RMW;
    bus.req_addr_i     = 32'h09;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_stb = 0;
    n_rsp = 0;
    if (bus.per_write_en_o) n_stb++;
    if (bus.rsp_valid_o) n_rsp++;
    @(negedge clk);
    reset       = 1'b0;
    model_paddr = 8'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.per_write_en_o) n_stb++;
      if (bus.rsp_valid_o) n_rsp++;
    end
    total++; if (n_stb !== 0)             begin bad++; $display("FAIL abort_strobes got=%0d want=0", n_stb); end
    total++; if (n_rsp !== 0)             begin bad++; $display("FAIL abort_rsp got=%0d want=0", n_rsp); end
    total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", bus.req_ready_o); end
    total++; if (tb_mem[2] !== ref_mem[2]) begin bad++; $display("FAIL abort_mem got=%h want=%h", tb_mem[2], ref_mem[2]); end
    $display("txn reset abort strobes=%0d rsps=%0d", n_stb, n_rsp);
  endtask

  task automatic test_back_to_back_random;
    logic        we, uns;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          mism;
    for (int t = 0; t < 200; t++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom);
      a   = $urandom;
      wd  = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      model_access(we, a, sz, uns, wd, x_err, x_rd, x_lat, x_nstb, x_pa, x_wv);
      run_txn(we, a, sz, uns, wd, g_lat, g_err, g_rd, g_nstb, g_wa, g_wv, g_pa1, g_tail);
      total++; if (g_lat !== x_lat)   begin bad++; $display("FAIL rnd_lat t=%0d got=%0d want=%0d", t, g_lat, x_lat); end
      total++; if (g_err !== x_err)   begin bad++; $display("FAIL rnd_err t=%0d got=%b want=%b", t, g_err, x_err); end
      total++; if (g_rd !== x_rd)     begin bad++; $display("FAIL rnd_rdata t=%0d got=%h want=%h", t, g_rd, x_rd); end
      total++; if (g_nstb !== x_nstb) begin bad++; $display("FAIL rnd_strobes t=%0d got=%0d want=%0d", t, g_nstb, x_nstb); end
      total++; if (g_pa1 !== x_pa)    begin bad++; $display("FAIL rnd_paddr t=%0d got=%h want=%h", t, g_pa1, x_pa); end
      total++; if (g_tail !== 1'b1)   begin bad++; $display("FAIL rnd_tail t=%0d got=%b want=1", t, g_tail); end
      if (x_nstb == 1) begin
        total++; if (g_wv !== x_wv)   begin bad++; $display("FAIL rnd_wdata t=%0d got=%h want=%h", t, g_wv, x_wv); end
      end
      $display("txn %0d we=%b sz=%0d a=%h err=%b rd=%h lat=%0d", t, we, sz, a[7:0], g_err, g_rd, g_lat);
    end
    mism = 0;
    for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
    total++; if (mism !== 0) begin bad++; $display("FAIL mem_final mismatched_words=%0d want=0", mism); end
  endtask

  initial begin
    poke_en            = 1'b0;
    poke_idx           = 6'd0;
    poke_val           = 32'h0;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_addr_i     = 32'h0;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = 32'h0;
    model_paddr        = 8'h0;
    reset              = 1'b1;
    test_reset();
    test_word_store();
    test_byte_load();
    test_misaligned();
    test_subword_store();
    test_reset_abort();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_initiator.md
MMIO_INITIATOR -- requirements
Module: mmio_initiator

Interface
REQ-001 Parameter: PER_ADDR_W, default 8, width of the peripheral word address bus.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req_valid_i  input  1  CPU load/store request valid.
REQ-005 Port: req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
REQ-006 Port: req_we_i  input  1  1 = store, 0 = load.
REQ-007 Port: req_addr_i  input  32  byte address; bits [31:PER_ADDR_W] ignored.
REQ-008 Port: req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 Port: req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 Port: req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port: rsp_valid_o  output  1  one-cycle response pulse; no backpressure.
REQ-012 Port: rsp_rdata_o  output  32  load result; 0 for stores and errors.
REQ-013 Port: rsp_err_o  output  1  request rejected; valid with rsp_valid_o.
REQ-014 Port: per_addr_o  output  PER_ADDR_W  word-aligned peripheral address ({req_addr_i[PER_ADDR_W-1:2], 2'b00}).
REQ-015 Port: per_write_en_o  output  1  one-cycle peripheral write strobe.
REQ-016 Port: per_data_o  output  32  full-word peripheral write data.
REQ-017 Port: per_data_i  input  32  combinational peripheral read data for per_addr_o.

Function
REQ-018 FSM states IDLE, READ, WRITE, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-019 On acceptance, addr, size, we, unsigned and wdata SHALL be latched; inputs are ignored until the FSM returns to IDLE.
REQ-020 Error cases: size 11; half with addr[0]=1; word with addr[1:0]!=0. Each SHALL go IDLE->RESP with rsp_err_o=1 and no peripheral write.
REQ-021 Load: IDLE->READ->RESP; per_data_i captured at end of READ; rsp_valid_o 2 cycles after acceptance.
REQ-022 Load extraction: select byte lane addr[1:0] or half lane addr[1]; extend per req_unsigned_i; word is unchanged.
REQ-023 Word store: IDLE->WRITE->RESP; per_write_en_o=1 and per_data_o=wdata in WRITE; rsp 2 cycles after acceptance.
REQ-024 Sub-word store (RMW): IDLE->READ->WRITE->RESP. Merged word = captured read word with the addressed lane(s) replaced by wdata; rsp 3 cycles after acceptance.
REQ-025 per_write_en_o SHALL be 1 only in WRITE, exactly one cycle per store.
REQ-026 per_addr_o and per_data_o SHALL hold their last driven values outside active states.
REQ-027 RESP SHALL last one cycle, then IDLE; back-to-back accepts are possible every 2-4 cycles.

Reset
REQ-028 While reset=1: state IDLE, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, per_write_en_o=0, per_addr_o=0, per_data_o=0, all latches 0.
REQ-029 Reset asserted in any state SHALL abort the access with no write strobe and no response.

Configuration
REQ-030 Macro MMIO_INIT_RMW_EN defined: sub-word stores use RMW per REQ-024.
REQ-031 Macro undefined: sub-word stores are errors (IDLE->RESP, rsp_err_o=1, no write); sub-word loads are unaffected.

Structure
REQ-032 Package mmio_pkg SHALL hold the size enum (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and a PER_ADDR_W default constant.
REQ-033 One combinational sub-module, mmio_lane_align, SHALL perform load extraction and store merge.

Verification
REQ-034 Word store 0x12345678 @0x10 -> WRITE cycle: per_addr 0x10, per_data 0x12345678, strobe 1 for 1 cycle; rsp_valid at T+2, err 0.
REQ-035 Byte load @0x05 with per_data_i=0x000080FF -> per_addr 0x04; signed rsp_rdata 0xFFFFFF80, unsigned 0x00000080; rsp at T+2.
REQ-036 (RMW_EN) Byte store 0xAB @0x02 over word 0x11223344 -> READ, then WRITE with per_data 0x11AB3344, rsp at T+3.
REQ-037 Half load @0x03 -> rsp_valid at T+1, err 1, rdata 0, no strobe, per_addr unchanged.
REQ-038 Reset pulsed during READ of an RMW -> no strobe, no rsp_valid, req_ready_o=1 after release.
REQ-039 (no RMW_EN) Half store @0x00 -> rsp at T+1, err 1, no strobe.
